// File: rtl/spi_xfer_arbiter.sv
// Shares one SPI master among NREQ requesters: arbitrates, runs one LSB-first transfer, pulses Done.
// Define SPI_RR_ARB_EN for round-robin arbitration; otherwise the lowest requester index wins.
module spi_xfer_arbiter #(
    parameter int NREQ      = 2,
    parameter int NUMSLAVES = 2,
    parameter int DWIDTH    = 8,
    parameter int CLKDIV    = 2
) (
    input  logic                                Clock,
    input  logic                                Reset_N,
    input  logic [NREQ-1:0]                     Req,
    input  logic [NREQ*DWIDTH-1:0]              TxData,
    input  logic [NREQ*$clog2(NUMSLAVES)-1:0]   SlvId,
    output logic [NREQ-1:0]                     Done,
    output logic [DWIDTH-1:0]                   RxData,
    output logic                                Busy,
    output logic                                SCLK,
    output logic                                MOSI,
    output logic [NUMSLAVES-1:0]                SS,
    input  logic [NUMSLAVES-1:0]                MISO,
    output logic [2:0]                          dbg_state
);

    localparam int IDW  = $clog2(NUMSLAVES);
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int DIVW = $clog2(CLKDIV + 1);
    localparam int BITW = $clog2(DWIDTH + 1);
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);
    localparam logic [BITW-1:0] BIT_LAST = BITW'(DWIDTH - 1);
    localparam logic [IDW:0]    NSLV     = (IDW + 1)'(NUMSLAVES);
    localparam logic [GW-1:0]   LAST_REQ = GW'(NREQ - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [DWIDTH-1:0]   sr_q, sr_d;
    logic                rx_q, rx_d;
    logic                mosi_q, mosi_d;
    logic                sclk_q, sclk_d;
    logic [NUMSLAVES-1:0] ss_q, ss_d;
    logic                phase_q, phase_d;
    logic [DIVW-1:0]     div_q, div_d;
    logic [BITW-1:0]     bit_q, bit_d;
    logic [DWIDTH-1:0]   rx_data_q, rx_data_d;

    logic [GW-1:0]       win;
    logic [DWIDTH-1:0]   tx_sel;
    logic [IDW-1:0]      id_sel;
    logic                sel_ok;
    logic                id_ok;

`ifdef SPI_RR_ARB_EN
    logic [GW-1:0]       rr_q, rr_d;
    logic                found;

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && Req[(int'(rr_q) + k) % NREQ]) begin
                found = 1'b1;
                win   = GW'((int'(rr_q) + k) % NREQ);
            end
        end
    end
`else
    always_comb begin
        win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (Req[k]) win = GW'(k);
        end
    end
`endif

    assign tx_sel = TxData[int'(win)*DWIDTH +: DWIDTH];
    assign id_sel = SlvId[int'(win)*IDW +: IDW];
    // Out-of-range ids still run the full timing but never touch the bus.
    assign sel_ok = ({1'b0, id_sel} < NSLV);
    assign id_ok  = ({1'b0, id_q} < NSLV);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        sr_d      = sr_q;
        rx_d      = rx_q;
        mosi_d    = mosi_q;
        sclk_d    = sclk_q;
        ss_d      = ss_q;
        phase_d   = phase_q;
        div_d     = div_q;
        bit_d     = bit_q;
        rx_data_d = rx_data_q;
`ifdef SPI_RR_ARB_EN
        rr_d      = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|Req) begin
                    grant_d = win;
                    id_d    = id_sel;
                    sr_d    = tx_sel;
                    mosi_d  = tx_sel[0];
                    ss_d    = sel_ok ? ~(NUMSLAVES'(1) << id_sel) : '1;
                    sclk_d  = 1'b0;
                    rx_d    = 1'b0;
                    phase_d = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = id_ok;
                        rx_d    = id_ok & MISO[id_q];
                    end else begin
                        // Falling edge: shift the sampled bit in at the top, present the next bit.
                        phase_d = 1'b0;
                        sclk_d  = 1'b0;
                        sr_d    = {rx_q, sr_q[DWIDTH-1:1]};
                        if (bit_q == BIT_LAST) begin
                            mosi_d  = 1'b0;
                            state_d = ST_HOLD;
                        end else begin
                            mosi_d = sr_q[1];
                            bit_d  = bit_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d     = '0;
                    ss_d      = '1;
                    rx_data_d = sr_q;
                    state_d   = ST_DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DONE: begin
`ifdef SPI_RR_ARB_EN
                rr_d = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_N) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            sr_q      <= '0;
            rx_q      <= 1'b0;
            mosi_q    <= 1'b0;
            sclk_q    <= 1'b0;
            ss_q      <= '1;
            phase_q   <= 1'b0;
            div_q     <= '0;
            bit_q     <= '0;
            rx_data_q <= '0;
`ifdef SPI_RR_ARB_EN
            rr_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            sr_q      <= sr_d;
            rx_q      <= rx_d;
            mosi_q    <= mosi_d;
            sclk_q    <= sclk_d;
            ss_q      <= ss_d;
            phase_q   <= phase_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            rx_data_q <= rx_data_d;
`ifdef SPI_RR_ARB_EN
            rr_q      <= rr_d;
`endif
        end
    end

    assign Done      = (state_q == ST_DONE) ? (NREQ'(1) << grant_q) : '0;
    assign Busy      = (state_q != ST_IDLE);
    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;
    assign SS        = ss_q;
    assign RxData    = rx_data_q;
    assign dbg_state = state_q;

endmodule
